// File: rtl/ooo_types.sv
// Shared out-of-order core types: rename/free-list geometry and the circular
// pointer type used for occupancy arithmetic by the free list, rename and ROB.
package ooo_types;

    localparam int NUM_PHYS_REGS = 128;
    localparam int PHYS_REG_BITS = 7;
    localparam int NUM_ARCH_REGS = 32;
    localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int NUM_CKPT      = 4;
    localparam int CKPT_BITS     = 2;

    typedef logic [PHYS_REG_BITS-1:0] preg_t;

    typedef struct packed {
        logic       wrap;
        logic [6:0] idx;
    } fl_ptr_t;

    // Depth is not a power of two, so the index wraps explicitly at FL_DEPTH-1.
    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        fl_ptr_t r;
        if (p.idx == 7'(FL_DEPTH - 1)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + 7'd1;
            r.wrap = p.wrap;
        end
        return r;
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register tags: allocates at rename, reclaims
// at commit, and rolls the head back to a per-branch snapshot on mispredict.
module free_list
    import ooo_types::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_req,
    output logic                     alloc_valid,
    output logic [PHYS_REG_BITS-1:0] alloc_preg,
    input  logic                     free_en,
    input  logic [PHYS_REG_BITS-1:0] free_preg,
    input  logic                     ckpt_en,
    input  logic [CKPT_BITS-1:0]     ckpt_id,
    input  logic                     restore_en,
    input  logic [CKPT_BITS-1:0]     restore_id,
    output logic [6:0]               free_count,
    output logic                     empty
);

    preg_t   fl_q   [FL_DEPTH];
    preg_t   fl_d   [FL_DEPTH];
    fl_ptr_t ckpt_q [NUM_CKPT];
    fl_ptr_t ckpt_d [NUM_CKPT];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;

    fl_ptr_t    head_adv;
    logic [7:0] count_full;
    logic       full;
    logic       alloc_fire;
    logic       free_fire;

    always_comb begin
        if (head_q.wrap == tail_q.wrap) begin
            count_full = {1'b0, tail_q.idx} - {1'b0, head_q.idx};
        end else begin
            count_full = 8'(FL_DEPTH) - {1'b0, head_q.idx} + {1'b0, tail_q.idx};
        end
        free_count  = count_full[6:0];
        empty       = (count_full == 8'd0);
        full        = (count_full == 8'(FL_DEPTH));
        alloc_valid = !empty;
        alloc_preg  = fl_q[head_q.idx];
    end

    // Restore wins over allocation and checkpointing; commits still free.
    always_comb begin
        alloc_fire = alloc_req && alloc_valid && !restore_en;
        free_fire  = free_en && (free_preg != '0) && !full;

        head_adv = alloc_fire ? ptr_inc(head_q) : head_q;
        head_d   = restore_en ? ckpt_q[restore_id] : head_adv;
        tail_d   = free_fire ? ptr_inc(tail_q) : tail_q;

        fl_d = fl_q;
        if (free_fire) begin
            fl_d[tail_q.idx] = free_preg;
        end

        ckpt_d = ckpt_q;
        if (ckpt_en && !restore_en) begin
            ckpt_d[ckpt_id] = head_adv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '{wrap: 1'b0, idx: 7'd0};
            tail_q <= '{wrap: 1'b1, idx: 7'd0};
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= preg_t'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < NUM_CKPT; c++) begin
                ckpt_q[c] <= '{wrap: 1'b0, idx: 7'd0};
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fl_q   <= fl_d;
            ckpt_q <= ckpt_d;
        end
    end

    // Commit can never return more tags than the list has room for.
    a_no_free_when_full: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(free_en && (free_preg != '0) && full)
    );

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a position-log model.
module tb_free_list;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_valid;
    logic [6:0] alloc_preg;
    logic       free_en;
    logic [6:0] free_preg;
    logic       ckpt_en;
    logic [1:0] ckpt_id;
    logic       restore_en;
    logic [1:0] restore_id;
    logic [6:0] free_count;
    logic       empty;

    int checks = 0;
    int errors = 0;

    free_list dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .free_en     (free_en),
        .free_preg   (free_preg),
        .ckpt_en     (ckpt_en),
        .ckpt_id     (ckpt_id),
        .restore_en  (restore_en),
        .restore_id  (restore_id),
        .free_count  (free_count),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every tag ever placed in the list, in order, plus the absolute
    // positions of the next allocation (head) and next insertion (tail).
    logic [6:0] log_q[$];
    int head_pos;
    int tail_pos;
    int ckpt_pos[4];

    function automatic int m_count();
        return tail_pos - head_pos;
    endfunction

    function automatic logic [6:0] m_tag();
        if (head_pos < log_q.size()) return log_q[head_pos];
        return 7'd0;
    endfunction

    task automatic model_reset();
        log_q.delete();
        for (int i = 0; i < 96; i++) log_q.push_back(7'(32 + i));
        head_pos = 0;
        tail_pos = 96;
        for (int c = 0; c < 4; c++) ckpt_pos[c] = 0;
    endtask

    task automatic idle_inputs();
        alloc_req  = 1'b0;
        free_en    = 1'b0;
        free_preg  = 7'd0;
        ckpt_en    = 1'b0;
        ckpt_id    = 2'd0;
        restore_en = 1'b0;
        restore_id = 2'd0;
    endtask

    // Called at posedge+1; drives one cycle, updates the model, returns at next posedge+1.
    task automatic step(input logic a, input logic fe, input logic [6:0] fp,
                        input logic ce, input logic [1:0] ci,
                        input logic re, input logic [1:0] ri);
        int  grant;
        int  new_head;
        alloc_req  = a;
        free_en    = fe;
        free_preg  = fp;
        ckpt_en    = ce;
        ckpt_id    = ci;
        restore_en = re;
        restore_id = ri;
        grant    = (a && m_count() > 0 && !re) ? 1 : 0;
        new_head = re ? ckpt_pos[ri] : head_pos + grant;
        if (ce && !re) ckpt_pos[ci] = head_pos + grant;
        if (fe && fp != 7'd0 && m_count() < 96) begin
            log_q.push_back(fp);
            tail_pos++;
        end
        head_pos = new_head;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic alloc_once();
        step(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic free_once(input logic [6:0] tag);
        step(1'b0, 1'b1, tag, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        checks++;
        if (alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b want 1", alloc_valid); end
        checks++;
        if (alloc_preg !== 7'd32) begin errors++; $display("FAIL reset_preg got %0d want 32", alloc_preg); end
        checks++;
        if (free_count !== 7'd96) begin errors++; $display("FAIL reset_count got %0d want 96", free_count); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %0b want 0", empty); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (alloc_valid !== 1'b1 || alloc_preg !== 7'(32 + i)) begin
                errors++;
                $display("FAIL drain_tag[%0d] got %0d/v%0b want %0d/v1", i, alloc_preg, alloc_valid, 32 + i);
            end
            checks++;
            if (free_count !== 7'(96 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, free_count, 96 - i); end
            alloc_once();
        end
        checks++;
        if (empty !== 1'b1 || alloc_valid !== 1'b0 || free_count !== 7'd0) begin
            errors++;
            $display("FAIL drain_empty got e%0b v%0b c%0d want e1 v0 c0", empty, alloc_valid, free_count);
        end
        alloc_once();
        checks++;
        if (free_count !== 7'd0 || alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_97th got c%0d v%0b want c0 v0", free_count, alloc_valid);
        end
    endtask

    task automatic test_free_while_empty();
        checks++;
        if (alloc_valid !== 1'b0) begin errors++; $display("FAIL fwe_pre_valid got %0b want 0", alloc_valid); end
        step(1'b1, 1'b1, 7'd45, 1'b0, 2'd0, 1'b0, 2'd0);
        checks++;
        if (alloc_preg !== 7'd45 || alloc_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwe_tag got %0d/v%0b want 45/v1", alloc_preg, alloc_valid);
        end
        checks++;
        if (free_count !== 7'd1) begin errors++; $display("FAIL fwe_count got %0d want 1", free_count); end
        alloc_once();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL fwe_drained got %0b want 1", empty); end
    endtask

    task automatic test_ckpt_restore();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alloc_preg !== 7'(32 + i)) begin errors++; $display("FAIL cr_pre[%0d] got %0d want %0d", i, alloc_preg, 32 + i); end
            alloc_once();
        end
        checks++;
        if (alloc_preg !== 7'd35) begin errors++; $display("FAIL cr_ckpt_tag got %0d want 35", alloc_preg); end
        step(1'b1, 1'b0, 7'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        alloc_once();
        checks++;
        if (alloc_preg !== 7'd37) begin errors++; $display("FAIL cr_post_tag got %0d want 37", alloc_preg); end
        alloc_once();
        step(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd1);
        checks++;
        if (alloc_preg !== 7'd36) begin errors++; $display("FAIL cr_restore_tag got %0d want 36", alloc_preg); end
        checks++;
        if (free_count !== 7'd92) begin errors++; $display("FAIL cr_restore_count got %0d want 92", free_count); end
    endtask

    task automatic test_restore_priority();
        alloc_once();
        step(1'b1, 1'b0, 7'd0, 1'b1, 2'd2, 1'b0, 2'd0);
        checks++;
        if (free_count !== 7'd90) begin errors++; $display("FAIL rp_pre_count got %0d want 90", free_count); end
        step(1'b1, 1'b1, 7'd7, 1'b1, 2'd2, 1'b1, 2'd1);
        checks++;
        if (alloc_preg !== 7'd36) begin errors++; $display("FAIL rp_head got %0d want 36", alloc_preg); end
        checks++;
        if (free_count !== 7'd93) begin errors++; $display("FAIL rp_count got %0d want 93", free_count); end
        step(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        checks++;
        if (alloc_preg !== 7'd38 || free_count !== 7'd91) begin
            errors++;
            $display("FAIL rp_slot2_kept got %0d/c%0d want 38/c91", alloc_preg, free_count);
        end
        for (int i = 0; i < 90; i++) alloc_once();
        checks++;
        if (alloc_preg !== 7'd7 || free_count !== 7'd1) begin
            errors++;
            $display("FAIL rp_tail_tag got %0d/c%0d want 7/c1", alloc_preg, free_count);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] pat[$];
        do_reset();
        for (int i = 0; i < 50; i++) alloc_once();
        for (int i = 0; i < 50; i++) free_once(7'((200 + 37 * i) % 127 + 1));
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (alloc_preg !== m_tag() || free_count !== 7'(96 - i)) begin
                errors++;
                $display("FAIL wrap_a[%0d] got %0d/c%0d want %0d/c%0d", i, alloc_preg, free_count, m_tag(), 96 - i);
            end
            alloc_once();
        end
        for (int i = 0; i < 96; i++) begin
            pat.push_back(7'((200 * (i + 1)) % 127 + 1));
            checks++;
            if (free_count !== 7'(i)) begin errors++; $display("FAIL wrap_f[%0d] got %0d want %0d", i, free_count, i); end
            free_once(pat[i]);
        end
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (alloc_preg !== pat[i] || free_count !== 7'(96 - i)) begin
                errors++;
                $display("FAIL wrap_b[%0d] got %0d/c%0d want %0d/c%0d", i, alloc_preg, free_count, pat[i], 96 - i);
            end
            alloc_once();
        end
    endtask

    task automatic test_random();
        logic       a, fe, ce, re;
        logic [6:0] fp;
        logic [1:0] ci, ri;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom_range(0, 99) < 55);
            fe = ($urandom_range(0, 99) < 50) && (m_count() < 96);
            fp = 7'($urandom_range(0, 127));
            ce = ($urandom_range(0, 9) == 0);
            ci = 2'($urandom_range(0, 3));
            ri = 2'($urandom_range(0, 3));
            re = ($urandom_range(0, 19) == 0) && (ckpt_pos[ri] <= tail_pos) && (tail_pos - ckpt_pos[ri] <= 95);
            step(a, fe, fp, ce, ci, re, ri);
            checks++;
            if (free_count !== 7'(m_count()) || empty !== (m_count() == 0) || alloc_valid !== (m_count() != 0)) begin
                errors++;
                $display("FAIL rand_count[%0d] got c%0d e%0b v%0b want c%0d", n, free_count, empty, alloc_valid, m_count());
            end
            if (m_count() > 0) begin
                checks++;
                if (alloc_preg !== m_tag()) begin
                    errors++;
                    $display("FAIL rand_tag[%0d] got %0d want %0d", n, alloc_preg, m_tag());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) alloc_once();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_preg !== 7'd32 || free_count !== 7'd96 || empty !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got v%0b p%0d c%0d e%0b want v1 p32 c96 e0", alloc_valid, alloc_preg, free_count, empty);
        end
        free_en   = 1'b1;
        free_preg = 7'd9;
        alloc_req = 1'b1;
        #8;
        checks++;
        if (alloc_preg !== 7'd32 || free_count !== 7'd96) begin
            errors++;
            $display("FAIL async_hold got p%0d c%0d want p32 c96", alloc_preg, free_count);
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        free_once(7'd0);
        checks++;
        if (free_count !== 7'd96) begin errors++; $display("FAIL zero_full got %0d want 96", free_count); end
        alloc_once();
        free_once(7'd0);
        checks++;
        if (free_count !== 7'd95 || alloc_preg !== 7'd33) begin
            errors++;
            $display("FAIL zero_ignored got c%0d p%0d want c95 p33", free_count, alloc_preg);
        end
        for (int i = 1; i < 96; i++) begin
            checks++;
            if (alloc_preg !== 7'(32 + i)) begin errors++; $display("FAIL post_rst[%0d] got %0d want %0d", i, alloc_preg, 32 + i); end
            alloc_once();
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty got %0b want 1", empty); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_drain();
        test_free_while_empty();
        test_ckpt_restore();
        test_restore_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
